// File: rtl/control_unit_mc_if.sv
// Control-unit bus: opcode, ALU flags and memory handshake in; datapath/memory strobes out.
// master = control unit side, slave = datapath/memory side.
interface control_unit_mc_if #(
    parameter int OPCODE_W = 6
);
    logic [OPCODE_W-1:0] opcode;
    logic                Z, N, C, O;
    logic                mem_ready;

    logic                alu_enable;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                ir_load;
    logic                pc_enable;
    logic                pc_load;
    logic                branch_taken;
    logic [1:0]          alu_src;
    logic                call_push;
    logic                ret_pop;
    logic [3:0]          state;
    logic                halted;
    logic                fault;

    modport master (
        input  opcode, Z, N, C, O, mem_ready,
        output alu_enable, reg_write, mem_read, mem_write, ir_load, pc_enable,
               pc_load, branch_taken, alu_src, call_push, ret_pop, state, halted, fault
    );

    modport slave (
        output opcode, Z, N, C, O, mem_ready,
        input  alu_enable, reg_write, mem_read, mem_write, ir_load, pc_enable,
               pc_load, branch_taken, alu_src, call_push, ret_pop, state, halted, fault
    );
endinterface

// File: rtl/control_unit_mc.sv
// Multi-cycle control FSM for the ITSC CPU core (FETCH/DECODE/EXECUTE/MEM/WRITEBACK/BRANCH/HALT).
// Optional memory-wait watchdog enabled by defining CU_MEM_TIMEOUT_EN.
module control_unit_mc #(
    parameter int OPCODE_W    = 6,
    parameter int STACK_DEPTH = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    control_unit_mc_if.master cu
);
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXECUTE   = 4'd2,
        S_MEM       = 4'd3,
        S_WRITEBACK = 4'd4,
        S_BRANCH    = 4'd5,
        S_HALT      = 4'd7
    } state_e;

    typedef logic [OPCODE_W-1:0] op_t;
    localparam op_t OP_MOV      = op_t'(13);
    localparam op_t OP_ALU_LAST = op_t'(17);
    localparam op_t OP_BRZ      = op_t'(18);
    localparam op_t OP_BRN      = op_t'(19);
    localparam op_t OP_BRC      = op_t'(20);
    localparam op_t OP_BRO      = op_t'(21);
    localparam op_t OP_BRA      = op_t'(22);
    localparam op_t OP_JMP      = op_t'(23);
    localparam op_t OP_RET      = op_t'(24);
    localparam op_t OP_LOAD     = op_t'(25);
    localparam op_t OP_STORE    = op_t'(26);
    localparam op_t OP_CALL     = op_t'(27);
    localparam op_t OP_HALT     = op_t'(63);

    localparam int                 DEPTH_W   = $clog2(STACK_DEPTH + 1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

    state_e             state_q, state_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               taken_q, taken_d;
    logic               fault_q, fault_d;
`ifdef CU_MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
    logic [WAIT_W-1:0]  wait_q, wait_d;
`endif

    logic is_alu, is_mov, is_load, is_store, is_call, is_ret, is_branch, is_halt_op;
    logic cond;
    logic call_ovf, ret_unf;

    assign is_mov     = (cu.opcode == OP_MOV);
    assign is_alu     = (cu.opcode <= OP_ALU_LAST) && !is_mov;
    assign is_load    = (cu.opcode == OP_LOAD);
    assign is_store   = (cu.opcode == OP_STORE);
    assign is_call    = (cu.opcode == OP_CALL);
    assign is_ret     = (cu.opcode == OP_RET);
    assign is_branch  = ((cu.opcode >= OP_BRZ) && (cu.opcode <= OP_RET)) || is_call;
    assign is_halt_op = (cu.opcode == OP_HALT);
    assign call_ovf   = is_call && (depth_q == DEPTH_MAX);
    assign ret_unf    = is_ret && (depth_q == '0);

    always_comb begin
        case (cu.opcode)
            OP_BRZ:                  cond = cu.Z;
            OP_BRN:                  cond = cu.N;
            OP_BRC:                  cond = cu.C;
            OP_BRO:                  cond = cu.O;
            OP_BRA, OP_JMP, OP_CALL: cond = 1'b1;
            OP_RET:                  cond = (depth_q != '0);
            default:                 cond = 1'b0;
        endcase
    end

    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        taken_d = taken_q;
        fault_d = fault_q;
        case (state_q)
            S_FETCH:     if (cu.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                taken_d = cond;
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (is_alu || is_mov)           state_d = S_FETCH;
                else if (is_load || is_store)   state_d = S_MEM;
                else if (is_branch)             state_d = S_BRANCH;
                else if (is_halt_op)            state_d = S_HALT;
                else begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_MEM:       if (cu.mem_ready) state_d = is_load ? S_WRITEBACK : S_FETCH;
            S_WRITEBACK: state_d = S_FETCH;
            S_BRANCH: begin
                if (call_ovf || ret_unf) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    if (is_call) depth_d = depth_q + 1'b1;
                    if (is_ret)  depth_d = depth_q - 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_HALT:      state_d = S_HALT;
            default: begin
                fault_d = 1'b1;
                state_d = S_HALT;
            end
        endcase
`ifdef CU_MEM_TIMEOUT_EN
        // Counter is zero whenever the FSM is not stalled, so it starts clean on entry.
        wait_d = '0;
        if ((state_q == S_FETCH || state_q == S_MEM) && !cu.mem_ready) begin
            if (wait_q == WAIT_W'(TIMEOUT_CYC - 1)) begin
                fault_d = 1'b1;
                state_d = S_HALT;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            depth_q <= '0;
            taken_q <= 1'b0;
            fault_q <= 1'b0;
`ifdef CU_MEM_TIMEOUT_EN
            wait_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            taken_q <= taken_d;
            fault_q <= fault_d;
`ifdef CU_MEM_TIMEOUT_EN
            wait_q  <= wait_d;
`endif
        end
    end

    // Outputs are gated by reset so a FETCH-state mem_read never leaks while reset is held.
    always_comb begin
        cu.alu_enable   = 1'b0;
        cu.reg_write    = 1'b0;
        cu.mem_read     = 1'b0;
        cu.mem_write    = 1'b0;
        cu.ir_load      = 1'b0;
        cu.pc_enable    = 1'b0;
        cu.pc_load      = 1'b0;
        cu.branch_taken = 1'b0;
        cu.alu_src      = 2'b00;
        cu.call_push    = 1'b0;
        cu.ret_pop      = 1'b0;
        cu.state        = 4'd0;
        cu.halted       = 1'b0;
        cu.fault        = 1'b0;
        if (!reset) begin
            cu.state        = state_q;
            cu.halted       = (state_q == S_HALT);
            cu.fault        = fault_q;
            cu.branch_taken = taken_q;
            case (state_q)
                S_FETCH: begin
                    cu.mem_read  = 1'b1;
                    cu.ir_load   = cu.mem_ready;
                    cu.pc_enable = cu.mem_ready;
                end
                S_EXECUTE: begin
                    cu.alu_enable = is_alu || is_mov;
                    cu.reg_write  = is_alu || is_mov;
                    cu.alu_src    = is_mov ? 2'b01 : 2'b00;
                end
                S_MEM: begin
                    cu.mem_read  = is_load;
                    cu.mem_write = !is_load;
                    cu.alu_src   = is_load ? 2'b10 : 2'b00;
                end
                S_WRITEBACK: begin
                    cu.reg_write = 1'b1;
                    cu.alu_src   = 2'b10;
                end
                S_BRANCH: begin
                    cu.pc_load   = taken_q && !call_ovf;
                    cu.call_push = is_call && !call_ovf;
                    cu.ret_pop   = is_ret && !ret_unf;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_control_unit_mc.sv
// Scoreboard bench for control_unit_mc: an instruction-level model queues per-cycle expected
// outputs, and a monitor compares them against the DUT on every falling edge.
`timescale 1ns/1ps
module tb_control_unit_mc;
    localparam int OPCODE_W    = 6;
    localparam int STACK_DEPTH = 2;
    localparam int TIMEOUT_CYC = 4;

    logic clk = 1'b0;
    logic reset;

    control_unit_mc_if #(.OPCODE_W(OPCODE_W)) bus ();

    control_unit_mc #(
        .OPCODE_W   (OPCODE_W),
        .STACK_DEPTH(STACK_DEPTH),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .cu   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       alu_enable;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       ir_load;
        logic       pc_enable;
        logic       pc_load;
        logic       branch_taken;
        logic [1:0] alu_src;
        logic       call_push;
        logic       ret_pop;
        logic [3:0] state;
        logic       halted;
        logic       fault;
    } outs_t;

    typedef struct {
        outs_t o;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Architectural model state
    int   m_depth  = 0;
    logic m_fault  = 1'b0;
    logic m_taken  = 1'b0;
    bit   m_halted = 1'b0;
    int   cur_op   = 0;
    int   instr_no = 0;

    task automatic check(input string name, input outs_t act, input outs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic outs_t sample();
        outs_t a;
        a.alu_enable   = bus.alu_enable;
        a.reg_write    = bus.reg_write;
        a.mem_read     = bus.mem_read;
        a.mem_write    = bus.mem_write;
        a.ir_load      = bus.ir_load;
        a.pc_enable    = bus.pc_enable;
        a.pc_load      = bus.pc_load;
        a.branch_taken = bus.branch_taken;
        a.alu_src      = bus.alu_src;
        a.call_push    = bus.call_push;
        a.ret_pop      = bus.ret_pop;
        a.state        = bus.state;
        a.halted       = bus.halted;
        a.fault        = bus.fault;
        return a;
    endfunction

    // Monitor: one comparison per cycle that has a queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check(e.tag, sample(), e.o);
            end
        end
    end

    function automatic outs_t mk(input int st);
        outs_t o = '0;
        o.state        = 4'(st);
        o.halted       = (st == 7);
        o.fault        = m_fault;
        o.branch_taken = m_taken;
        return o;
    endfunction

    function automatic logic cond(input int op, input logic [3:0] f);
        case (op)
            18:         return f[3];
            19:         return f[2];
            20:         return f[1];
            21:         return f[0];
            22, 23, 27: return 1'b1;
            24:         return (m_depth > 0);
            default:    return 1'b0;
        endcase
    endfunction

    task automatic step(input logic rst, input logic rdy, input logic [3:0] fl,
                        input outs_t e, input string tag);
        @(posedge clk);
        #1;
        reset         = rst;
        bus.opcode    = OPCODE_W'(cur_op);
        bus.mem_ready = rdy;
        {bus.Z, bus.N, bus.C, bus.O} = fl;
        exp_q.push_back('{o: e, tag: tag});
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 4'($urandom), '0, "reset");
        m_depth  = 0;
        m_fault  = 1'b0;
        m_taken  = 1'b0;
        m_halted = 1'b0;
    endtask

    task automatic run_halt(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom), mk(7), "halt");
    endtask

    // n stall cycles showing strobes e; reports whether the watchdog would fire.
    task automatic stall(input int n, input outs_t e, input logic [3:0] fl,
                         input string tag, output bit timed_out);
        timed_out = 1'b0;
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, fl, e, tag);
`ifdef CU_MEM_TIMEOUT_EN
            if (i + 1 == TIMEOUT_CYC) begin
                m_fault   = 1'b1;
                m_halted  = 1'b1;
                timed_out = 1'b1;
                return;
            end
`endif
        end
    endtask

    task automatic run_instr(input int op, input int fw, input int mw,
                             input logic [3:0] dfl, input logic [3:0] ofl, input bit abort_mem);
        outs_t e;
        bit    to;
        string tag;
        bit    alu   = (op <= 17) && (op != 13);
        bit    mov   = (op == 13);
        bit    memop = (op == 25) || (op == 26);
        bit    br    = (op >= 18 && op <= 24) || (op == 27);
        instr_no++;
        cur_op = op;
        tag = $sformatf("i%0d_op%0d", instr_no, op);

        e = mk(0); e.mem_read = 1'b1;
        stall(fw, e, ofl, {tag, "_fetch_wait"}, to);
        if (to) return;
        e.ir_load = 1'b1; e.pc_enable = 1'b1;
        step(1'b0, 1'b1, ofl, e, {tag, "_fetch"});

        step(1'b0, 1'($urandom_range(0, 1)), dfl, mk(1), {tag, "_decode"});
        m_taken = cond(op, dfl);

        e = mk(2);
        if (alu || mov) begin
            e.alu_enable = 1'b1; e.reg_write = 1'b1; e.alu_src = mov ? 2'b01 : 2'b00;
        end
        step(1'b0, 1'($urandom_range(0, 1)), ofl, e, {tag, "_execute"});
        if (alu || mov) return;
        if (!memop && !br) begin
            if (op != 63) m_fault = 1'b1;
            m_halted = 1'b1;
            return;
        end

        if (memop) begin
            e = mk(3);
            if (op == 25) begin e.mem_read = 1'b1; e.alu_src = 2'b10; end
            else          e.mem_write = 1'b1;
            stall(mw, e, ofl, {tag, "_mem_wait"}, to);
            if (to) return;
            if (abort_mem) begin
                do_reset();
                return;
            end
            step(1'b0, 1'b1, ofl, e, {tag, "_mem"});
            if (op == 25) begin
                e = mk(4); e.reg_write = 1'b1; e.alu_src = 2'b10;
                step(1'b0, 1'($urandom_range(0, 1)), ofl, e, {tag, "_writeback"});
            end
            return;
        end

        e = mk(5);
        if (op == 27 && m_depth == STACK_DEPTH) begin
            step(1'b0, 1'($urandom_range(0, 1)), ofl, e, {tag, "_call_overflow"});
            m_fault = 1'b1; m_halted = 1'b1;
        end else if (op == 24 && m_depth == 0) begin
            e.pc_load = m_taken;
            step(1'b0, 1'($urandom_range(0, 1)), ofl, e, {tag, "_ret_underflow"});
            m_fault = 1'b1; m_halted = 1'b1;
        end else begin
            e.pc_load   = m_taken;
            e.call_push = (op == 27);
            e.ret_pop   = (op == 24);
            step(1'b0, 1'($urandom_range(0, 1)), ofl, e, {tag, "_branch"});
            if (op == 27) m_depth++;
            if (op == 24) m_depth--;
        end
    endtask

    function automatic int pick_op();
        int r = $urandom_range(0, 99);
        int x;
        if (r < 35) begin
            x = $urandom_range(0, 16);
            if (x >= 13) x++;
            return x;
        end
        if (r < 42) return 13;
        if (r < 52) return 25;
        if (r < 62) return 26;
        if (r < 82) return $urandom_range(18, 24);
        if (r < 94) return 27;
        if (r < 97) return $urandom_range(28, 62);
        return 63;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset         = 1'b1;
        bus.opcode    = '0;
        bus.mem_ready = 1'b0;
        {bus.Z, bus.N, bus.C, bus.O} = 4'h0;
        do_reset();

        // ADD, then LOAD with three MEM waits
        run_instr(0, 0, 0, 4'h0, 4'h0, 1'b0);
        run_instr(25, 0, 3, 4'h0, 4'h0, 1'b0);
        // BRZ: decision taken from DECODE-cycle Z, not EXECUTE-cycle Z
        run_instr(18, 0, 0, 4'b1000, 4'b0000, 1'b0);
        run_instr(18, 0, 0, 4'b0000, 4'b1000, 1'b0);
        // CALL nesting overflow at depth STACK_DEPTH
        for (int i = 0; i < 3; i++) run_instr(27, 0, 0, 4'h0, 4'h0, 1'b0);
        run_halt(3);
        // RET underflow at depth 0
        do_reset();
        run_instr(24, 0, 0, 4'hF, 4'hF, 1'b0);
        run_halt(2);
        // Illegal opcode
        do_reset();
        run_instr(40, 0, 0, 4'h0, 4'h0, 1'b0);
        run_halt(2);
        // Reset in the middle of a STORE access
        do_reset();
        run_instr(26, 1, 2, 4'h0, 4'h0, 1'b1);
        run_instr(13, 0, 0, 4'h0, 4'h0, 1'b0);
`ifdef CU_MEM_TIMEOUT_EN
        run_instr(0, 10, 0, 4'h0, 4'h0, 1'b0);
        run_halt(3);
        do_reset();
`else
        run_instr(0, 100, 0, 4'h0, 4'h0, 1'b0);
`endif

        for (int n = 0; n < 300; n++) begin
            if (m_halted) begin
                run_halt(1);
                do_reset();
            end
            run_instr(pick_op(), $urandom_range(0, 3), $urandom_range(0, 3),
                      4'($urandom), 4'($urandom), 1'b0);
        end

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain actual=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/control_unit_mc.md
Name: control_unit_mc

Overview:
Parametrised multi-cycle control FSM for the ITSC CPU core.
- Decodes the latched opcode and sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK/BRANCH.
- Uses a ready handshake with instruction/data memory.
- Registers the branch decision and tracks CALL/RET depth, with stack fault detection.
- Drives the ALU, register file, PC and memory strobes.

Parameters:
OPCODE_W, 6, opcode width; opcode encodings below are zero-extended to this width.
STACK_DEPTH, 8, maximum CALL nesting tracked by the internal depth counter; must be ≥1.
TIMEOUT_CYC, 255, maximum mem_ready wait cycles (used only with the optional feature).

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
opcode  in  OPCODE_W  opcode of the current instruction; valid from the cycle after ir_load
Z, N, C, O  in  1 each  ALU flags
mem_ready  in  1  memory completes the current mem_read/mem_write this cycle
alu_enable  out  1  ALU operate
reg_write  out  1  register file write strobe
mem_read  out  1  memory read request (held until mem_ready)
mem_write  out  1  memory write request (held until mem_ready)
ir_load  out  1  latch fetched instruction
pc_enable  out  1  PC increment
pc_load  out  1  PC load branch target
branch_taken  out  1  registered branch decision
alu_src  out  2  00 register, 01 immediate, 10 memory data
call_push  out  1  push return address
ret_pop  out  1  pop return address
state  out  4  current FSM state
halted  out  1  FSM in HALT
fault  out  1  sticky fault flag

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, BRANCH=5, HALT=7.
- Reset:
  - state=FETCH, depth=0, branch_taken=0, fault=0.
  - While reset=1, every output is forced to 0, including mem_read.
  - Reset asserted mid-access aborts the access with no completion strobe.
- Outputs are decoded from the registered state, opcode and internal registers. No output depends combinationally on mem_ready, except ir_load/pc_enable/reg_write on the completion cycle as listed below.
- FETCH:
  - mem_read=1.
  - If mem_ready=0, stay in FETCH.
  - If mem_ready=1: ir_load=1, pc_enable=1 in that same cycle, then go to DECODE.
- DECODE (1 cycle):
  - branch_taken <= condition. BRZ(18)=Z, BRN(19)=N, BRC(20)=C, BRO(21)=O; BRA(22), JMP(23), CALL(27)=1; RET(24)=1 iff depth>0; otherwise 0.
  - Go to EXECUTE.
- EXECUTE, by opcode:
  - 0–12 and 14–17 (arith/logic/shift): alu_enable=1, reg_write=1, alu_src=00, then FETCH.
  - 13 MOV: alu_enable=1, reg_write=1, alu_src=01, then FETCH.
  - 25 LOAD: go to MEM.
  - 26 STORE: go to MEM.
  - 18–24 and 27 (branch/jump/call/ret): go to BRANCH.
  - 63 HALT: go to HALT.
  - Any other opcode: fault<=1, go to HALT.
- MEM:
  - LOAD: mem_read=1, alu_src=10. On mem_ready, go to WRITEBACK.
  - STORE: mem_write=1. On mem_ready, go to FETCH.
  - Strobes are held steady while mem_ready=0.
- WRITEBACK (1 cycle): reg_write=1, alu_src=10, then FETCH.
- BRANCH (1 cycle): pc_load=branch_taken, then FETCH.
  - CALL:
    - If depth<STACK_DEPTH: call_push=1, depth+1.
    - If depth==STACK_DEPTH: fault<=1, pc_load=0, go to HALT.
  - RET:
    - If depth>0: ret_pop=1, depth−1.
    - If depth==0: fault<=1, go to HALT (underflow).
- HALT:
  - halted=1; all strobes 0.
  - Exit only via reset.
- Latency: ALU op 3 cycles; LOAD 5 cycles; STORE 4 cycles; branch 4 cycles (each with zero memory wait). Every mem_ready wait cycle adds 1.
- mem_ready asserted outside FETCH/MEM is ignored.
- fault clears only on reset.

Optional Feature:
CU_MEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to FETCH or MEM and increments each cycle that mem_ready=0 in those states.
  - When it reaches TIMEOUT_CYC: fault<=1, drop the strobes, go to HALT.
- Undefined: no counter; the FSM waits indefinitely for mem_ready.

Test Plan:
- ADD (opcode 0), mem_ready=1 always → states 0,1,2; reg_write=1 only in cycle 3; back to FETCH in cycle 4.
- LOAD (25) with mem_ready held low 3 cycles in MEM → mem_read high 4 cycles in MEM; WRITEBACK reg_write=1, alu_src=10; total 8 cycles.
- BRZ (18): Z=1 in DECODE, then Z=0 in EXECUTE → branch_taken=1 and pc_load=1 in BRANCH (registered decision). With Z=0 in DECODE → pc_load=0.
- With STACK_DEPTH=2: three CALLs (27) → first two give call_push=1; third sets fault=1, halted=1. Fresh reset, then RET with depth 0 → fault=1, ret_pop=0.
- Opcode 40 → fault=1, halted=1, state=7. Assert reset mid-MEM → all outputs 0 immediately, state=0, fault=0.
- With CU_MEM_TIMEOUT_EN and TIMEOUT_CYC=4: mem_ready=0 forever in FETCH → HALT with fault=1 after 4 wait cycles. Without the macro → still in FETCH after 100 cycles.
